muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit: WIDTH+3 cycles from start to valid pulse.
// No queueing: start is only sampled in IDLE, busy stalls the issuer, cancel flushes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_x;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_divzero;

  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_bzero;
  logic               w_last;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_a_neg  = w_signed & r_a[WIDTH-1];
  assign w_b_neg  = w_signed & r_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -r_a : r_a;
  assign w_b_mag  = w_b_neg ? -r_b : r_b;

  // Shift-add step: low product bits shift into r_q as multiplier bits retire.
  assign w_addend = r_q[0] ? r_m : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  // Restoring step: the true difference always fits WIDTH bits when w_ge holds.
  assign w_shift  = {r_acc, r_q[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_m});
  assign w_diff   = w_shift[WIDTH-1:0] - r_m;

  assign w_prod   = {r_acc, r_q};
  assign w_prod_s = r_neg_x ? -w_prod : w_prod;
  assign w_quo    = r_neg_x ? -r_q : r_q;
  assign w_rem    = r_neg_r ? -r_acc : r_acc;
  assign w_bzero  = (r_b == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_x   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_divzero <= 1'b0;
    end else if (r_state != S_IDLE && cancel) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_acc <= '0;
          r_cnt <= '0;
          if (w_is_div) begin
            r_m     <= w_b_mag;
            r_q     <= w_a_mag;
            r_neg_x <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
          end else begin
            r_m     <= w_a_mag;
            r_q     <= w_b_mag;
            r_neg_x <= w_a_neg ^ w_b_neg;
            r_neg_r <= 1'b0;
          end
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_is_div) begin
            r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (w_is_div && w_bzero) begin
            // Zero divisor reports the raw dividend, bypassing sign correction.
            r_hi      <= r_a;
            r_lo      <= '1;
            r_divzero <= 1'b1;
          end else if (w_is_div) begin
            r_hi      <= w_rem;
            r_lo      <= w_quo;
            r_divzero <= 1'b0;
          end else begin
            r_hi      <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo      <= w_prod_s[WIDTH-1:0];
            r_divzero <= 1'b0;
          end
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign valid   = r_valid;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign divzero = r_divzero;

endmodule
